// File: rtl/clock_time_ctrl_pkg.sv
// Shared encodings, limits and widths for the 12-hour clock time controller.
// The optional hourly chime is selected with the HOURLY_CHIME_EN macro.
package clock_ctrl_pkg;

  localparam int HR_W = 4;
  localparam int MS_W = 6;

  localparam logic [MS_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MS_W-1:0] MIN_MAX = 6'd59;
  localparam logic [HR_W-1:0] HR_MAX  = 4'd11;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_e;

  // Modulo-60 step for the minute and second fields; never exceeds the maximum.
  function automatic logic [MS_W-1:0] inc_mod60(input logic [MS_W-1:0] v);
    return (v == MIN_MAX) ? '0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/clock_time_ctrl_if.sv
// Link to the external mod-12 hour next-state incrementer.
// Handshake: the master drives HR_CS and pulls HR_EN_N low for one cycle; the slave
// answers combinationally on HR_NS, which the master loads on that same rising edge.
interface clock_time_ctrl_if;
  logic [clock_ctrl_pkg::HR_W-1:0] HR_CS;
  logic                            HR_EN_N;
  logic [clock_ctrl_pkg::HR_W-1:0] HR_NS;

  modport master (output HR_CS, output HR_EN_N, input HR_NS);
  modport slave  (input HR_CS, input HR_EN_N, output HR_NS);
endinterface

// File: rtl/clock_time_ctrl_sec_prescaler.sv
// Clock-cycle prescaler producing a one-cycle sec_tick every TICKS_PER_SEC enabled cycles.
// Holds its count while disabled; clr forces the count back to zero.
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic sec_tick
);

  localparam int CW = $clog2(TICKS_PER_SEC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt_q;

  assign sec_tick = en && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      if (cnt_q == CNT_LAST) cnt_q <= '0;
      else                   cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/clock_time_ctrl.sv
// Time-keeping and set-mode controller for a 12-hour clock; sequences the external
// mod-12 hour incrementer. Define HOURLY_CHIME_EN to build the hourly chime pulse.
module clock_time_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    MODE_BTN,
  input  logic                    INC_BTN,
  clock_time_ctrl_if.master       hr,
  output logic [MS_W-1:0]         MIN,
  output logic [MS_W-1:0]         SEC,
  output logic                    PM,
  output logic [1:0]              MODE,
  output logic                    ERR,
  output logic                    CHIME
);

  mode_e            mode_q;
  logic [HR_W-1:0]  hr_q;
  logic [MS_W-1:0]  min_q;
  logic [MS_W-1:0]  sec_q;
  logic             pm_q;
  logic             err_q;

  logic sec_tick;
  logic presc_clr;
  logic hr_adv_run;
  logic hr_adv_set;
  logic hr_adv;
  logic ns_bad;

  // Leaving SET_MIN restarts the second from zero.
  assign presc_clr = (mode_q == MODE_SET_MIN) && MODE_BTN;

  sec_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_presc (
    .clk      (CLK),
    .rst      (RST),
    .en       (mode_q == MODE_RUN),
    .clr      (presc_clr),
    .sec_tick (sec_tick)
  );

  // MODE_BTN takes priority over INC_BTN, so a simultaneous INC never advances the hour.
  assign hr_adv_run = sec_tick && (sec_q == SEC_MAX) && (min_q == MIN_MAX);
  assign hr_adv_set = (mode_q == MODE_SET_HR) && INC_BTN && !MODE_BTN;
  assign hr_adv     = !RST && (hr_adv_run || hr_adv_set);
  assign ns_bad     = hr.HR_NS > HR_MAX;

  assign hr.HR_CS   = hr_q;
  assign hr.HR_EN_N = !hr_adv;

  assign MIN  = min_q;
  assign SEC  = sec_q;
  assign PM   = pm_q;
  assign MODE = mode_q;
  assign ERR  = err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q <= MODE_RUN;
      hr_q   <= '0;
      min_q  <= '0;
      sec_q  <= '0;
      pm_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (mode_q)
        MODE_RUN:    if (MODE_BTN) mode_q <= MODE_SET_HR;
        MODE_SET_HR: if (MODE_BTN) mode_q <= MODE_SET_MIN;
        MODE_SET_MIN: begin
          if (MODE_BTN) begin
            mode_q <= MODE_RUN;
            sec_q  <= '0;
          end else if (INC_BTN) begin
            min_q <= inc_mod60(min_q);
          end
        end
        default: mode_q <= MODE_RUN;
      endcase

      // sec_tick only fires in RUN, so it never collides with the SET_MIN writes.
      if (sec_tick) begin
        if (sec_q == SEC_MAX) begin
          sec_q <= '0;
          min_q <= inc_mod60(min_q);
        end else begin
          sec_q <= sec_q + 6'd1;
        end
      end

      if (hr_adv) begin
        if (ns_bad) begin
          hr_q  <= '0;
          err_q <= 1'b1;
        end else begin
          hr_q <= hr.HR_NS;
          if (hr_q == HR_MAX) pm_q <= !pm_q;
        end
      end
    end
  end

`ifdef HOURLY_CHIME_EN
  logic chime_q;

  always_ff @(posedge CLK) begin
    if (RST) chime_q <= 1'b0;
    else     chime_q <= hr_adv && hr_adv_run && !ns_bad;
  end

  assign CHIME = chime_q;
`else
  assign CHIME = 1'b0;
`endif

endmodule
